// File: rtl/io_switch_led.sv
// -----------------------------------------------------------------------------
// io_switch_led
//   Memory-mapped switch/LED peripheral sitting behind the MemOrIO stage.
//   Holds a 24-bit LED register written through two 16-bit windows, and
//   synchronises + debounces 24 raw board switches into a stable register
//   that can be read back through two 16-bit windows. LED contents are also
//   readable. Strobes to unmapped addresses raise a one-cycle addr_err pulse.
//
// Ports
//   clk        in   1   system clock, rising edge
//   rst_n      in   1   asynchronous active-low reset
//   led_ctrl   in   1   LED chip select (write strobe)
//   sw_ctrl    in   1   switch chip select (read strobe)
//   io_addr    in   32  data address
//   io_wdata   in   16  low 16 bits of write data
//   sw_in      in   24  raw asynchronous board switches
//   io_rdata   out  16  combinational read data
//   led_out    out  24  LED drive register
//   sw_changed out  1   one-cycle pulse when the debounced value updates
//   addr_err   out  1   registered one-cycle pulse on unmapped access
// -----------------------------------------------------------------------------
module io_switch_led #(
    parameter int          DB_LIMIT    = 1_000_000,
    parameter int          DB_CNT_W    = 20,
    parameter logic [31:0] LED_LO_ADDR = 32'hFFFF_FC60,
    parameter logic [31:0] LED_HI_ADDR = 32'hFFFF_FC62,
    parameter logic [31:0] SW_LO_ADDR  = 32'hFFFF_FC70,
    parameter logic [31:0] SW_HI_ADDR  = 32'hFFFF_FC72
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        led_ctrl,
    input  logic        sw_ctrl,
    input  logic [31:0] io_addr,
    input  logic [15:0] io_wdata,
    input  logic [23:0] sw_in,
    output logic [15:0] io_rdata,
    output logic [23:0] led_out,
    output logic        sw_changed,
    output logic        addr_err
);

    // Terminal count: the counter rests here once the candidate has been
    // steady for DB_LIMIT cycles.
    localparam logic [DB_CNT_W-1:0] CNT_MAX = DB_CNT_W'(DB_LIMIT - 1);
    localparam logic [DB_CNT_W-1:0] CNT_ONE = DB_CNT_W'(1);

    logic [23:0]         sync1_r;
    logic [23:0]         sync2_r;
    logic [23:0]         cand_r;
    logic [23:0]         sw_stable_r;
    logic [DB_CNT_W-1:0] cnt_r;

    logic                led_lo_hit_s;
    logic                led_hi_hit_s;
    logic                wr_hit_s;
    logic                rd_hit_s;
    logic [15:0]         rdata_s;

    // Write-side address decode: only the two LED windows are writable.
    always_comb begin
        led_lo_hit_s = (io_addr == LED_LO_ADDR);
        led_hi_hit_s = (io_addr == LED_HI_ADDR);
        wr_hit_s     = led_lo_hit_s | led_hi_hit_s;
    end

    // Read mux: switches and LEDs are both readable; upper byte windows
    // return zero-extended 8-bit values.
    always_comb begin
        rdata_s  = 16'h0000;
        rd_hit_s = 1'b0;
        if (sw_ctrl) begin
            case (io_addr)
                SW_LO_ADDR: begin
                    rdata_s  = sw_stable_r[15:0];
                    rd_hit_s = 1'b1;
                end
                SW_HI_ADDR: begin
                    rdata_s  = {8'h00, sw_stable_r[23:16]};
                    rd_hit_s = 1'b1;
                end
                LED_LO_ADDR: begin
                    rdata_s  = led_out[15:0];
                    rd_hit_s = 1'b1;
                end
                LED_HI_ADDR: begin
                    rdata_s  = {8'h00, led_out[23:16]};
                    rd_hit_s = 1'b1;
                end
                default: begin
                    rdata_s  = 16'h0000;
                    rd_hit_s = 1'b0;
                end
            endcase
        end else begin
            rdata_s  = 16'h0000;
            rd_hit_s = 1'b0;
        end
    end

    assign io_rdata = rdata_s;

    // LED register: a same-cycle read still sees the old value because the
    // read mux is driven from this register, not from io_wdata.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            led_out <= 24'h00_0000;
        end else if (led_ctrl) begin
            if (led_lo_hit_s) begin
                led_out[15:0] <= io_wdata;
            end else if (led_hi_hit_s) begin
                led_out[23:16] <= io_wdata[7:0];
            end
        end
    end

    // Unmapped-access flag: either strobe missing its windows raises a pulse.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            addr_err <= 1'b0;
        end else begin
            addr_err <= (led_ctrl & ~wr_hit_s) | (sw_ctrl & ~rd_hit_s);
        end
    end

    // Two-flop synchroniser followed by a whole-vector debouncer: any bit
    // change in the synchronised value restarts the stability count.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_r     <= 24'h00_0000;
            sync2_r     <= 24'h00_0000;
            cand_r      <= 24'h00_0000;
            sw_stable_r <= 24'h00_0000;
            cnt_r       <= '0;
            sw_changed  <= 1'b0;
        end else begin
            sync1_r    <= sw_in;
            sync2_r    <= sync1_r;
            sw_changed <= 1'b0;
            if (sync2_r != cand_r) begin
                cand_r <= sync2_r;
                cnt_r  <= '0;
            end else if (cnt_r < CNT_MAX) begin
                cnt_r <= cnt_r + CNT_ONE;
            end else if (sw_stable_r != cand_r) begin
                // Counter saturated: candidate has been steady long enough.
                sw_stable_r <= cand_r;
                sw_changed  <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_io_switch_led.sv
// -----------------------------------------------------------------------------
// tb_io_switch_led
//   Directed self-checking bench for io_switch_led with DB_LIMIT=4.
//   Inputs are driven 1 ns after the rising edge and outputs are sampled
//   1 ns after the following rising edge.
// -----------------------------------------------------------------------------
module tb_io_switch_led;

    localparam logic [31:0] LED_LO = 32'hFFFF_FC60;
    localparam logic [31:0] LED_HI = 32'hFFFF_FC62;
    localparam logic [31:0] SW_LO  = 32'hFFFF_FC70;
    localparam logic [31:0] SW_HI  = 32'hFFFF_FC72;

    logic        clk;
    logic        rst_n;
    logic        led_ctrl;
    logic        sw_ctrl;
    logic [31:0] io_addr;
    logic [15:0] io_wdata;
    logic [23:0] sw_in;
    logic [15:0] io_rdata;
    logic [23:0] led_out;
    logic        sw_changed;
    logic        addr_err;

    int          checks;
    int          errors;
    logic [23:0] led_exp;

    io_switch_led #(
        .DB_LIMIT (4),
        .DB_CNT_W (3)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .led_ctrl   (led_ctrl),
        .sw_ctrl    (sw_ctrl),
        .io_addr    (io_addr),
        .io_wdata   (io_wdata),
        .sw_in      (sw_in),
        .io_rdata   (io_rdata),
        .led_out    (led_out),
        .sw_changed (sw_changed),
        .addr_err   (addr_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        // Put something in the LED register, then hit reset mid-cycle.
        led_ctrl = 1'b1; io_addr = LED_LO; io_wdata = 16'h1234;
        step();
        led_ctrl = 1'b0;
        checks++;
        if (led_out !== 24'h001234) begin
            errors++;
            $display("FAIL reset_pre_write: led_out=%h expected=%h", led_out, 24'h001234);
        end
        sw_ctrl = 1'b1; io_addr = LED_LO;
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if (led_out !== 24'h000000) begin
            errors++;
            $display("FAIL reset_led: led_out=%h expected=0", led_out);
        end
        checks++;
        if (io_rdata !== 16'h0000) begin
            errors++;
            $display("FAIL reset_rdata: io_rdata=%h expected=0", io_rdata);
        end
        checks++;
        if (sw_changed !== 1'b0 || addr_err !== 1'b0) begin
            errors++;
            $display("FAIL reset_pulses: sw_changed=%b addr_err=%b expected=0/0", sw_changed, addr_err);
        end
        sw_ctrl = 1'b0;
        step();
        rst_n = 1'b1;
        led_exp = 24'h000000;
    endtask

    task automatic test_led_write();
        led_ctrl = 1'b1; io_addr = LED_LO; io_wdata = 16'hA5C3;
        step();
        checks++;
        if (led_out !== 24'h00A5C3) begin
            errors++;
            $display("FAIL led_lo_write: led_out=%h expected=%h", led_out, 24'h00A5C3);
        end
        io_addr = LED_HI; io_wdata = 16'hFF7E;
        step();
        led_ctrl = 1'b0;
        checks++;
        if (led_out !== 24'h7EA5C3) begin
            errors++;
            $display("FAIL led_hi_write: led_out=%h expected=%h", led_out, 24'h7EA5C3);
        end
        sw_ctrl = 1'b1; io_addr = LED_HI;
        #1;
        checks++;
        if (io_rdata !== 16'h007E) begin
            errors++;
            $display("FAIL led_hi_read: io_rdata=%h expected=%h", io_rdata, 16'h007E);
        end
        io_addr = LED_LO;
        #1;
        checks++;
        if (io_rdata !== 16'hA5C3) begin
            errors++;
            $display("FAIL led_lo_read: io_rdata=%h expected=%h", io_rdata, 16'hA5C3);
        end
        sw_ctrl = 1'b0;
        led_exp = 24'h7EA5C3;
    endtask

    task automatic test_back_to_back();
        // Simultaneous write and read of the same window: old then new.
        led_ctrl = 1'b1; sw_ctrl = 1'b1; io_addr = LED_LO; io_wdata = 16'h1111;
        #1;
        checks++;
        if (io_rdata !== 16'hA5C3) begin
            errors++;
            $display("FAIL same_cycle_read: io_rdata=%h expected=%h", io_rdata, 16'hA5C3);
        end
        step();
        led_ctrl = 1'b0;
        #1;
        checks++;
        if (io_rdata !== 16'h1111) begin
            errors++;
            $display("FAIL read_after_write: io_rdata=%h expected=%h", io_rdata, 16'h1111);
        end
        checks++;
        if (addr_err !== 1'b0) begin
            errors++;
            $display("FAIL b2b_addr_err: addr_err=%b expected=0", addr_err);
        end
        sw_ctrl = 1'b0;
        led_exp = 24'h7E1111;
    endtask

    task automatic test_switch();
        sw_in = 24'h123456;
        sw_ctrl = 1'b1; io_addr = SW_LO;
        for (int k = 1; k <= 9; k++) begin
            step();
            checks++;
            if (io_rdata !== ((k >= 7) ? 16'h3456 : 16'h0000)) begin
                errors++;
                $display("FAIL sw_latency edge%0d: io_rdata=%h expected=%h", k, io_rdata,
                         (k >= 7) ? 16'h3456 : 16'h0000);
            end
            checks++;
            if (sw_changed !== ((k == 7) ? 1'b1 : 1'b0)) begin
                errors++;
                $display("FAIL sw_changed edge%0d: sw_changed=%b expected=%b", k, sw_changed, k == 7);
            end
        end
        io_addr = SW_HI;
        #1;
        checks++;
        if (io_rdata !== 16'h0012) begin
            errors++;
            $display("FAIL sw_hi_read: io_rdata=%h expected=%h", io_rdata, 16'h0012);
        end
        sw_ctrl = 1'b0;
    endtask

    task automatic test_glitch();
        sw_ctrl = 1'b1; io_addr = SW_LO;
        sw_in = 24'h123457;
        for (int k = 1; k <= 15; k++) begin
            step();
            if (k == 3) sw_in = 24'h123456;
            checks++;
            if (io_rdata !== 16'h3456 || sw_changed !== 1'b0) begin
                errors++;
                $display("FAIL glitch cycle%0d: io_rdata=%h sw_changed=%b expected=3456/0", k, io_rdata, sw_changed);
            end
        end
        sw_ctrl = 1'b0;
    endtask

    task automatic test_addr_err();
        led_ctrl = 1'b1; io_addr = 32'hFFFF_FC64; io_wdata = 16'hFFFF;
        #1;
        checks++;
        if (addr_err !== 1'b0) begin
            errors++;
            $display("FAIL addr_err_early: addr_err=%b expected=0", addr_err);
        end
        step();
        led_ctrl = 1'b0;
        checks++;
        if (led_out !== led_exp || addr_err !== 1'b1) begin
            errors++;
            $display("FAIL bad_write: led_out=%h addr_err=%b expected=%h/1", led_out, addr_err, led_exp);
        end
        step();
        checks++;
        if (addr_err !== 1'b0) begin
            errors++;
            $display("FAIL addr_err_width: addr_err=%b expected=0", addr_err);
        end
        sw_ctrl = 1'b1; io_addr = 32'h0000_0010;
        #1;
        checks++;
        if (io_rdata !== 16'h0000) begin
            errors++;
            $display("FAIL bad_read_data: io_rdata=%h expected=0", io_rdata);
        end
        step();
        sw_ctrl = 1'b0;
        checks++;
        if (addr_err !== 1'b1) begin
            errors++;
            $display("FAIL bad_read_err: addr_err=%b expected=1", addr_err);
        end
        step();
        checks++;
        if (addr_err !== 1'b0) begin
            errors++;
            $display("FAIL bad_read_width: addr_err=%b expected=0", addr_err);
        end
        // Valid LED write plus read strobe both serviced; no error.
        led_ctrl = 1'b1; sw_ctrl = 1'b1; io_addr = LED_HI; io_wdata = 16'h0042;
        step();
        led_ctrl = 1'b0; sw_ctrl = 1'b0;
        led_exp = 24'h421111;
        checks++;
        if (led_out !== led_exp || addr_err !== 1'b0) begin
            errors++;
            $display("FAIL dual_strobe: led_out=%h addr_err=%b expected=%h/0", led_out, addr_err, led_exp);
        end
    endtask

    task automatic test_reset_midcount();
        sw_in = 24'hABCDEF;
        // Edges 1..3 carry the value into cand (cnt=0), edges 4,5 take cnt to 2.
        for (int k = 1; k <= 5; k++) step();
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if (led_out !== 24'h000000 || sw_changed !== 1'b0) begin
            errors++;
            $display("FAIL midcount_reset: led_out=%h sw_changed=%b expected=0/0", led_out, sw_changed);
        end
        step();
        rst_n = 1'b1;
        sw_ctrl = 1'b1; io_addr = SW_LO;
        for (int k = 1; k <= 8; k++) begin
            step();
            checks++;
            if (io_rdata !== ((k >= 7) ? 16'hCDEF : 16'h0000) ||
                sw_changed !== ((k == 7) ? 1'b1 : 1'b0)) begin
                errors++;
                $display("FAIL reacquire edge%0d: io_rdata=%h sw_changed=%b expected=%h/%b", k, io_rdata,
                         sw_changed, (k >= 7) ? 16'hCDEF : 16'h0000, k == 7);
            end
        end
        checks++;
        if (led_out !== 24'h000000) begin
            errors++;
            $display("FAIL reacquire_led: led_out=%h expected=0", led_out);
        end
        sw_ctrl = 1'b0;
    endtask

    initial begin
        checks   = 0;
        errors   = 0;
        led_exp  = 24'h000000;
        rst_n    = 1'b0;
        led_ctrl = 1'b0;
        sw_ctrl  = 1'b0;
        io_addr  = 32'h0000_0000;
        io_wdata = 16'h0000;
        sw_in    = 24'h000000;
        step();
        step();
        rst_n = 1'b1;
        step();
        test_reset();
        test_led_write();
        test_back_to_back();
        test_switch();
        test_glitch();
        test_addr_err();
        test_reset_midcount();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
